// File: rtl/cnn_pkg.sv
// Shared types and constants for the conv MAC/pool stage: beat kinds,
// FSM states, SSFR op-byte bit positions and int8 saturation limits.
package cnn_pkg;

  typedef enum logic [1:0] {
    KIND_BIAS = 2'd0,
    KIND_TAP  = 2'd1,
    KIND_SSFR = 2'd2,
    KIND_RSVD = 2'd3
  } beat_kind_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  localparam int SSFR_RELU_BIT  = 7;
  localparam int SSFR_POOL_BIT  = 6;
  localparam int SSFR_SHIFT_MSB = 4;
  localparam int SSFR_SHIFT_LSB = 0;

  localparam logic signed [7:0] INT8_MAX = 8'sd127;
  localparam logic signed [7:0] INT8_MIN = -8'sd128;

endpackage

// File: rtl/conv_mac_pool_requant_lane.sv
// Combinational requantizer for one lane: rounding arithmetic right shift,
// optional ReLU, then saturation to int8.
module requant_lane
  import cnn_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [4:0]       shift_i,
  input  logic                    relu_en_i,
  output logic signed [7:0]       q_o
);

  // Wide enough that acc plus the largest rounding term (2^30) cannot overflow.
  localparam int EXT_W = ((ACC_W > 32) ? ACC_W : 32) + 2;

  function automatic logic signed [EXT_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] a,
    input logic        [4:0]       s
  );
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] half;
    ext  = {{(EXT_W-ACC_W){a[ACC_W-1]}}, a};
    half = '0;
    if (s != 5'd0) half[s - 5'd1] = 1'b1;
    return (ext + half) >>> s;
  endfunction

  function automatic logic signed [7:0] sat_int8(input logic signed [EXT_W-1:0] v);
    if (v > EXT_W'(INT8_MAX)) return INT8_MAX;
    if (v < EXT_W'(INT8_MIN)) return INT8_MIN;
    return v[7:0];
  endfunction

  logic signed [EXT_W-1:0] r;

  always_comb begin
    r = round_shift(acc_i, shift_i);
    if (relu_en_i && (r < 0)) r = '0;
    q_o = sat_int8(r);
  end

endmodule

// File: rtl/conv_mac_pool.sv
// Four-lane convolution MAC fed by the sequencer's framed stream, followed by
// requantization, optional ReLU / 2x2 max-pool and an int8 result drain.
module conv_mac_pool
  import cnn_pkg::*;
#(
  parameter int ACC_W      = 24,
  parameter int BIAS_SHIFT = 0,
  parameter int MAX_TAPS   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  in_kind,
  input  logic [7:0]  in_px0,
  input  logic [7:0]  in_px1,
  input  logic [7:0]  in_px2,
  input  logic [7:0]  in_px3,
  input  logic [7:0]  in_param,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic [1:0]  out_lane,
  output logic        busy,
  output logic        err_frame,
  output logic        err_overrun,
  output logic [15:0] frame_count
);

  localparam logic [7:0] MAX_N = 8'(MAX_TAPS);

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q [4];
  logic        [7:0]       n_q, tap_cnt_q;
  logic signed [7:0]       buf_q [4];
  logic        [1:0]       drain_idx_q;
  logic                    drain_act_q;
  logic                    out_valid_q;
  logic signed [7:0]       out_data_q;
  logic        [1:0]       out_lane_q;
  logic                    err_frame_q, err_overrun_q;
  logic        [15:0]      frame_cnt_q;

  logic                    load_bias, do_mac, do_ssfr, frame_err;
  logic                    n_ok;
  logic        [7:0]       px [4];
  logic signed [16:0]      prod [4];
  logic signed [ACC_W-1:0] bias_load;
  logic signed [7:0]       q [4];
  logic signed [7:0]       pool_max;

  function automatic logic signed [7:0] max4(
    input logic signed [7:0] a,
    input logic signed [7:0] b,
    input logic signed [7:0] c,
    input logic signed [7:0] d
  );
    logic signed [7:0] m_ab, m_cd;
    m_ab = (a > b) ? a : b;
    m_cd = (c > d) ? c : d;
    return (m_ab > m_cd) ? m_ab : m_cd;
  endfunction

  assign px[0] = in_px0;
  assign px[1] = in_px1;
  assign px[2] = in_px2;
  assign px[3] = in_px3;

  assign n_ok      = (in_px1 != 8'd0) && (in_px1 <= MAX_N);
  assign bias_load = ACC_W'($signed(in_param)) <<< BIAS_SHIFT;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      prod[i] = $signed({1'b0, px[i]}) * $signed(in_param);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_bias = 1'b0;
    do_mac    = 1'b0;
    do_ssfr   = 1'b0;
    frame_err = 1'b0;
    if (in_valid) begin
      case (beat_kind_t'(in_kind))
        KIND_BIAS: begin
          // A BIAS mid-frame is an error but still restarts the frame.
          if (state_q == ST_ACC) frame_err = 1'b1;
          if (n_ok) begin
            load_bias = 1'b1;
            state_d   = ST_ACC;
          end else begin
            frame_err = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        KIND_TAP: begin
          if ((state_q == ST_ACC) && (tap_cnt_q != n_q)) do_mac = 1'b1;
          else frame_err = 1'b1;
        end
        KIND_SSFR: begin
          if (state_q == ST_ACC) begin
            state_d = ST_IDLE;
            if (tap_cnt_q == n_q) do_ssfr = 1'b1;
            else frame_err = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    requant_lane #(.ACC_W(ACC_W)) u_rq (
      .acc_i     (acc_q[g]),
      .shift_i   (in_param[SSFR_SHIFT_MSB:SSFR_SHIFT_LSB]),
      .relu_en_i (in_param[SSFR_RELU_BIT]),
      .q_o       (q[g])
    );
  end

  assign pool_max = max4(q[0], q[1], q[2], q[3]);

  // Accumulate stage: registered MAC, so an SSFR sees the previous cycle's last TAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
      n_q       <= '0;
      tap_cnt_q <= '0;
    end else if (load_bias) begin
      for (int i = 0; i < 4; i++) acc_q[i] <= bias_load;
      n_q       <= in_px1;
      tap_cnt_q <= '0;
    end else if (do_mac) begin
      for (int i = 0; i < 4; i++) acc_q[i] <= acc_q[i] + ACC_W'(prod[i]);
      tap_cnt_q <= tap_cnt_q + 8'd1;
    end
  end

  // Output stage: pooled pulse or four-cycle lane drain from a private buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_lane_q    <= '0;
      drain_act_q   <= 1'b0;
      drain_idx_q   <= '0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      err_frame_q <= err_frame_q | frame_err;
      out_valid_q <= 1'b0;
      if (do_ssfr) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        if (drain_act_q) err_overrun_q <= 1'b1;
        out_valid_q <= 1'b1;
        out_lane_q  <= 2'd0;
        if (in_param[SSFR_POOL_BIT]) begin
          out_data_q  <= pool_max;
          drain_act_q <= 1'b0;
        end else begin
          out_data_q  <= q[0];
          drain_act_q <= 1'b1;
          drain_idx_q <= 2'd1;
        end
      end else if (drain_act_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= buf_q[drain_idx_q];
        out_lane_q  <= drain_idx_q;
        drain_idx_q <= drain_idx_q + 2'd1;
        if (drain_idx_q == 2'd3) drain_act_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_ssfr && !in_param[SSFR_POOL_BIT]) begin
      for (int i = 0; i < 4; i++) buf_q[i] <= q[i];
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_lane    = out_lane_q;
  assign busy        = (state_q == ST_ACC) | drain_act_q | out_valid_q;
  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_conv_mac_pool.sv
// Scoreboard bench for conv_mac_pool: frame driver pushes expected results,
// an independent monitor pops and compares them when out_valid appears.
module tb_conv_mac_pool;

  localparam int ACC_W      = 24;
  localparam int BIAS_SHIFT = 0;
  localparam int MAX_TAPS   = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_kind;
  logic [7:0]  in_px0, in_px1, in_px2, in_px3, in_param;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_lane;
  logic        busy, err_frame, err_overrun;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  conv_mac_pool #(.ACC_W(ACC_W), .BIAS_SHIFT(BIAS_SHIFT), .MAX_TAPS(MAX_TAPS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_kind(in_kind),
    .in_px0(in_px0), .in_px1(in_px1), .in_px2(in_px2), .in_px3(in_px3),
    .in_param(in_param), .out_valid(out_valid), .out_data(out_data),
    .out_lane(out_lane), .busy(busy), .err_frame(err_frame),
    .err_overrun(err_overrun), .frame_count(frame_count)
  );

  typedef struct {
    int stamp;
    int data;
    int lane;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   exp_err_frame   = 1'b0;
  bit   exp_err_overrun = 1'b0;
  int   exp_frames      = 0;
  int   last_unpooled_t = -100;
  int   tap_px [MAX_TAPS][4];
  int   tap_w  [MAX_TAPS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int requant(input longint acc, input int s, input bit relu);
    longint r;
    r = (acc + ((s > 0) ? (64'sd1 <<< (s - 1)) : 64'sd0)) >>> s;
    if (relu && r < 0) r = 0;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  // Monitor: every output pulse must match the oldest expectation, on its cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].stamp < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_out: no pulse at cycle %0d, expected data %0d lane %0d",
               sbq[0].stamp, sbq[0].data, sbq[0].lane);
      void'(sbq.pop_front());
    end
    if (out_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: pulse data %0d lane %0d at cycle %0d, none expected",
                 $signed(out_data), out_lane, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_cycle", cyc, e.stamp);
        chk("out_data", $signed(out_data), e.data);
        chk("out_lane", out_lane, e.lane);
      end
    end
  end

  task automatic beat(input int kind, input int p0, input int p1, input int p2,
                      input int p3, input int param);
    @(negedge clk);
    in_valid = 1'b1;
    in_kind  = 2'(kind);
    in_px0   = 8'(p0);
    in_px1   = 8'(p1);
    in_px2   = 8'(p2);
    in_px3   = 8'(p3);
    in_param = 8'(param);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_kind  = 2'($urandom);
      in_px0   = 8'($urandom);
      in_px1   = 8'($urandom);
      in_px2   = 8'($urandom);
      in_px3   = 8'($urandom);
      in_param = 8'($urandom);
    end
  endtask

  task automatic expect_results(input int t, input longint acc[4], input int op);
    int lanes[4];
    int mx;
    bit pool;
    if (t - last_unpooled_t <= 3) exp_err_overrun = 1'b1;
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].stamp > t) sbq.delete(k);
    end
    for (int l = 0; l < 4; l++) lanes[l] = requant(acc[l], op & 31, op[7]);
    pool = op[6];
    if (pool) begin
      mx = lanes[0];
      for (int l = 1; l < 4; l++) if (lanes[l] > mx) mx = lanes[l];
      sbq.push_back('{stamp: t + 1, data: mx, lane: 0});
      last_unpooled_t = -100;
    end else begin
      for (int l = 0; l < 4; l++) sbq.push_back('{stamp: t + 1 + l, data: lanes[l], lane: l});
      last_unpooled_t = t;
    end
    exp_frames = (exp_frames + 1) % 65536;
  endtask

  task automatic send_frame(input int bias, input int n, input int ntaps,
                            input int op, input int gap_pct);
    longint acc[4];
    for (int l = 0; l < 4; l++) acc[l] = longint'(bias) * (64'sd1 <<< BIAS_SHIFT);
    beat(0, $urandom_range(0, 255), n, $urandom_range(0, 255), $urandom_range(0, 255), bias);
    for (int i = 0; i < ntaps; i++) begin
      if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 2));
      beat(1, tap_px[i][0], tap_px[i][1], tap_px[i][2], tap_px[i][3], tap_w[i]);
      if (i == 0) chk("busy_in_acc", busy, 1);
      for (int l = 0; l < 4; l++) acc[l] += longint'(tap_px[i][l]) * longint'(tap_w[i]);
    end
    if ($urandom_range(0, 99) < gap_pct) idle(1);
    beat(2, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
         $urandom_range(0, 255), op);
    if (ntaps != n) exp_err_frame = 1'b1;
    else expect_results(cyc, acc, op);
  endtask

  task automatic fill_taps(input int p0, input int p1, input int p2, input int p3, input int w);
    for (int i = 0; i < MAX_TAPS; i++) begin
      tap_px[i][0] = p0; tap_px[i][1] = p1; tap_px[i][2] = p2; tap_px[i][3] = p3;
      tap_w[i] = w;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < MAX_TAPS; i++) begin
      for (int l = 0; l < 4; l++) tap_px[i][l] = $urandom_range(0, 255);
      tap_w[i] = $urandom_range(0, 255) - 128;
    end
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lane", out_lane, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_frame", err_frame, 0);
    chk("rst_err_overrun", err_overrun, 0);
    chk("rst_frame_count", frame_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_kind  = '0;
    in_px0   = '0; in_px1 = '0; in_px2 = '0; in_px3 = '0;
    in_param = '0;
    idle(3);
    @(negedge clk);
    reset = 1'b0;
    check_reset_values();

    // Sum and round: acc 11, (11+1)>>1 = 6, pooled.
    fill_taps(1, 1, 1, 1, 1);
    send_frame(2, 9, 9, 8'hC1, 0);
    idle(6);
    chk("frame_count_1", frame_count, exp_frames);

    // Pool selection across lanes 9, 18, 27, 36.
    fill_taps(1, 2, 3, 4, 1);
    send_frame(0, 9, 9, 8'h40, 0);
    idle(6);

    // Negative saturation, then ReLU clamp.
    fill_taps(255, 255, 255, 255, -128);
    send_frame(0, 9, 9, 8'h00, 0);
    idle(6);
    send_frame(0, 9, 9, 8'h80, 0);
    idle(6);

    // Short frame, stray beats in IDLE, illegal tap count.
    fill_taps(1, 1, 1, 1, 1);
    send_frame(0, 9, 8, 8'h40, 0);
    idle(1);
    chk("err_frame_short", err_frame, 1);
    chk("idle_after_short", busy, 0);
    beat(1, 1, 1, 1, 1, 1);
    beat(0, 0, 0, 0, 0, 5);
    idle(1);
    chk("idle_after_n0", busy, 0);
    beat(0, 0, MAX_TAPS + 1, 0, 0, 5);
    idle(1);
    chk("idle_after_nbig", busy, 0);
    chk("err_frame_sticky", err_frame, 1);
    fill_random();
    send_frame(-7, 5, 5, 8'h03, 0);
    idle(6);

    // Reset at tap 4 of a frame.
    fill_taps(1, 1, 1, 1, 1);
    beat(0, 0, 9, 0, 0, 2);
    for (int i = 0; i < 4; i++) beat(1, 1, 1, 1, 1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    exp_frames      = 0;
    exp_err_frame   = 1'b0;
    exp_err_overrun = 1'b0;
    last_unpooled_t = -100;
    check_reset_values();
    send_frame(2, 9, 9, 8'hC1, 0);
    idle(6);
    chk("frame_count_after_reset", frame_count, exp_frames);

    // Back-to-back N=1 unpooled frames overrun the drain.
    fill_random();
    send_frame(3, 1, 1, 8'h00, 0);
    for (int l = 0; l < 4; l++) tap_px[0][l] = $urandom_range(0, 255);
    tap_w[0] = $urandom_range(0, 255) - 128;
    send_frame(-5, 1, 1, 8'h01, 0);
    idle(7);
    chk("err_overrun", err_overrun, 1);
    chk("err_frame_clean", err_frame, 0);

    // Randomized frames with gaps.
    for (int f = 0; f < 40; f++) begin
      fill_random();
      send_frame($urandom_range(0, 255) - 128, $urandom_range(3, 12), 0, 0, 0);
    end
    idle(8);
    chk("scoreboard_empty", sbq.size(), 0);
    for (int f = 0; f < 40; f++) begin
      int n;
      fill_random();
      n = $urandom_range(3, 12);
      send_frame($urandom_range(0, 255) - 128, n, n, $urandom_range(0, 255), 25);
    end
    idle(8);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("final_err_frame", err_frame, exp_err_frame);
    chk("final_err_overrun", err_overrun, exp_err_overrun);
    chk("final_frame_count", frame_count, exp_frames);
    chk("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_mac_pool.md
# conv_mac_pool

Downstream consumer of the image/conv memory-read sequencer. Accepts the framed per-block stream the sequencer emits (bias cycle, N tap cycles of four pixels plus one shared weight, one SSFR instruction cycle). Accumulates four convolution lanes in parallel, then applies shift/round requantization, optional ReLU and optional 2x2 max-pool. Emits int8 activations toward the write-back path.

## Interface
- ACC_W, 24: lane accumulator width, signed
- BIAS_SHIFT, 0: left shift applied to the sign-extended int8 bias before it is loaded into the accumulators
- MAX_TAPS, 32: largest legal tap count per frame
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  stream beat valid; the sequencer cannot stall, so there is no ready
- in_kind  in  2  beat type: 0 BIAS, 1 TAP, 2 SSFR, 3 reserved (ignored)
- in_px0..in_px3  in  8 each  lane pixels, unsigned; on a BIAS beat in_px1 = tap count N
- in_param  in  8  signed weight (TAP), signed bias (BIAS), or SSFR op byte (SSFR)
- out_valid  out  1  result pulse
- out_data  out  8  signed int8 result
- out_lane  out  2  lane index; 0 when pooled
- busy  out  1  high in ACC state or while results are draining
- err_frame  out  1  sticky framing error
- err_overrun  out  1  sticky drain-overrun error
- frame_count  out  16  completed frames, wraps at 2^16

## Operation
- States: IDLE and ACC.
- IDLE, BIAS beat:
  - load all four accumulators with sext(bias) <<< BIAS_SHIFT
  - latch N = in_px1 and clear tap_cnt
  - go to ACC
- N of 0 or N > MAX_TAPS sets err_frame and the FSM stays in IDLE.
- ACC, TAP beat: acc[i] += px_i (zero-extended) * weight (signed), for every lane; tap_cnt++.
- ACC, BIAS beat: sets err_frame, reinitialises the frame, stays in ACC.
- ACC, SSFR beat with tap_cnt == N: execute SSFR, increment frame_count, return to IDLE.
- ACC, SSFR beat with tap_cnt != N: sets err_frame, discards the frame, returns to IDLE, no output.
- ACC, TAP beat when tap_cnt == N: sets err_frame; the beat is ignored.
- IDLE, TAP or SSFR beat: sets err_frame; the beat is ignored.
- SSFR op byte:
  - bit7 relu_en
  - bit6 pool_en
  - bit5 reserved
  - bits4:0 shift s
- Requantization, per lane:
  - r = (acc + (s>0 ? 1<<(s-1) : 0)) >>> s, arithmetic shift
  - if relu_en and r < 0, then r = 0
  - saturate r to [-128, 127]
- pool_en=1: the result is the maximum of the four requantized lanes.
- pool_en=0: all four lane values are latched into the drain buffer.
- The drain buffer is separate from the accumulators, so the next frame may start on the cycle after SSFR.
- An SSFR beat that would load the buffer while a drain is still in progress sets err_overrun. The new results overwrite the buffer and the drain restarts at lane 0.
- Error flags clear only on reset.

## Timing
- Reset values:
  - out_valid 0, out_data 0, out_lane 0
  - busy 0, err_frame 0, err_overrun 0
  - frame_count 0
  - state IDLE, accumulators 0
- The MAC is a one-cycle registered update, so the last TAP is visible to an SSFR beat on the next cycle.
- pool_en=1: out_valid pulses once, in the cycle after the SSFR beat (latency 1).
- pool_en=0: out_valid is high for 4 consecutive cycles starting the cycle after SSFR, with out_lane 0,1,2,3.
- Minimum legal frame length is N+2 beats. For N >= 3 the drain completes before the next SSFR can arrive.
- Gaps (in_valid=0) are allowed anywhere in a frame; the state holds.
- Reset asserted mid-frame or mid-drain:
  - aborts the frame
  - no out_valid in the following cycle
  - returns to IDLE
- frame_count wraps from 0xFFFF to 0.

## Structure
- Package cnn_pkg holds:
  - the beat_kind_t enum (BIAS/TAP/SSFR)
  - SSFR bit-position constants
  - the int8 saturation limits
- Sub-module requant_lane (combinational): acc, s and relu_en in; int8 out. Instantiated four times.

## Test plan
- Sum and round: bias 2, N=9, all px=1, w=1, SSFR 0xC1 → single out_valid with out_data 6, since acc is 11 and (11+1)>>1 = 6; frame_count becomes 1.
- Pool selection: bias 0, N=9, px lanes 1,2,3,4, w=1, SSFR 0x40 → out_data 36, out_lane 0.
- Saturation and ReLU: px 255, w=-128, N=9 (acc -293760).
  - SSFR 0x00 → four pulses, each -128, out_lane 0..3.
  - SSFR 0x80 → four pulses, each 0.
- Framing errors:
  - SSFR after 8 of 9 taps → err_frame=1, no out_valid, FSM back in IDLE.
  - The next good frame still produces correct output.
- Reset mid-frame: reset held for 1 cycle at tap 4 → all outputs return to their reset values; a new full frame yields the expected result.
- Overrun: N=1 frames back-to-back with pool_en=0 → err_overrun=1 and the drain restarts at lane 0 with the new values.
